// File: rtl/ex_operand_stage_if.sv
// ----------------------------------------------------------------------------
// ex_operand_stage_if
//   Bundles every non-clock/reset signal of ex_operand_stage.
//   master : upstream/pipeline side (drives ID fields, flush, EX/MEM and
//            MEM/WB producer info; observes stall and the EX outputs)
//   slave  : the operand stage itself
// Signals:
//   id_*            decoded instruction from ID
//   flush           branch/jump redirect, kills the instruction entering EX
//   mem_* / wb_*    EX/MEM and MEM/WB producers used for forwarding/hazards
//   stall           hold PC and IF/ID (combinational)
//   alu_a/b/op      ALU operands and op code
//   ex_*            registered control/destination and store data for EX/MEM
// ----------------------------------------------------------------------------
interface ex_operand_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [RW-1:0] id_rs_addr;
  logic [RW-1:0] id_rt_addr;
  logic [RW-1:0] id_dst_addr;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic          id_alu_src;
  logic [2:0]    id_alu_op;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          flush;
  logic          mem_reg_write;
  logic [RW-1:0] mem_dst_addr;
  logic [DW-1:0] mem_result;
  logic          wb_reg_write;
  logic [RW-1:0] wb_dst_addr;
  logic [DW-1:0] wb_result;
  logic          stall;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [RW-1:0] ex_dst_addr;
  logic [DW-1:0] ex_store_data;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_dst_addr, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_alu_src, id_alu_op,
           id_reg_write, id_mem_read, id_mem_write, flush,
           mem_reg_write, mem_dst_addr, mem_result,
           wb_reg_write, wb_dst_addr, wb_result,
    input  stall, alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_dst_addr, ex_store_data
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_dst_addr, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_alu_src, id_alu_op,
           id_reg_write, id_mem_read, id_mem_write, flush,
           mem_reg_write, mem_dst_addr, mem_result,
           wb_reg_write, wb_dst_addr, wb_result,
    output stall, alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_dst_addr, ex_store_data
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ----------------------------------------------------------------------------
// ex_operand_stage
//   ID/EX pipeline register plus EX-stage operand selection for a 5-stage MIPS
//   pipeline. Captures the decoded instruction, resolves RAW hazards by
//   forwarding from EX/MEM and MEM/WB or by stalling, and drives the ALU.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   ex_operand_stage_if.slave (ID fields, flush, producers, outputs)
// Configuration:
//   FORWARD_EN defined   : MEM/WB forwarding, stall only on load-use.
//   FORWARD_EN undefined : no forwarding, stall on any EX or MEM producer hit.
// ----------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic               clk,
  input  logic               rst,
  ex_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs_addr;
    logic [RW-1:0] rt_addr;
    logic [RW-1:0] dst_addr;
    logic          uses_rs;
    logic          uses_rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          alu_src;
    logic [2:0]    alu_op;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } id_ex_t;

  id_ex_t        id_ex_q, id_ex_d;
  logic          stall;
  logic          rs_live, rt_live;
  logic [DW-1:0] rs_fwd, rt_fwd;

  // A source only matters when ID holds a real instruction that reads a
  // nonzero register; $0 can never carry a dependency.
  assign rs_live = bus.id_valid & bus.id_uses_rs & (bus.id_rs_addr != '0);
  assign rt_live = bus.id_valid & bus.id_uses_rt & (bus.id_rt_addr != '0);

`ifdef FORWARD_EN
  logic ex_load;

  // Only a load in EX cannot be covered by forwarding: its data appears in WB
  // two cycles later, so the consumer waits one cycle and then takes wb_result.
  assign ex_load = id_ex_q.valid & id_ex_q.mem_read;
  assign stall   = (rs_live & ex_load & (bus.id_rs_addr == id_ex_q.dst_addr))
                 | (rt_live & ex_load & (bus.id_rt_addr == id_ex_q.dst_addr));

  // Youngest producer wins: EX/MEM before MEM/WB, else the register-file value.
  function automatic logic [DW-1:0] fwd_sel(
    input logic          used,
    input logic [RW-1:0] addr,
    input logic [DW-1:0] reg_data,
    input logic          mem_we,
    input logic [RW-1:0] mem_dst,
    input logic [DW-1:0] mem_res,
    input logic          wb_we,
    input logic [RW-1:0] wb_dst,
    input logic [DW-1:0] wb_res
  );
    if (used && addr != '0 && mem_we && mem_dst == addr) return mem_res;
    if (used && addr != '0 && wb_we && wb_dst == addr) return wb_res;
    return reg_data;
  endfunction

  assign rs_fwd = fwd_sel(id_ex_q.uses_rs, id_ex_q.rs_addr, id_ex_q.rs_data,
                          bus.mem_reg_write, bus.mem_dst_addr, bus.mem_result,
                          bus.wb_reg_write, bus.wb_dst_addr, bus.wb_result);
  assign rt_fwd = fwd_sel(id_ex_q.uses_rt, id_ex_q.rt_addr, id_ex_q.rt_data,
                          bus.mem_reg_write, bus.mem_dst_addr, bus.mem_result,
                          bus.wb_reg_write, bus.wb_dst_addr, bus.wb_result);
`else
  logic ex_write;

  // Without forwarding, wait until the producer has left MEM. WB needs no
  // stall because the register file writes through to the ID read ports.
  assign ex_write = id_ex_q.valid & id_ex_q.reg_write;
  assign stall    = (rs_live & ((ex_write & (bus.id_rs_addr == id_ex_q.dst_addr)) |
                                (bus.mem_reg_write & (bus.id_rs_addr == bus.mem_dst_addr))))
                  | (rt_live & ((ex_write & (bus.id_rt_addr == id_ex_q.dst_addr)) |
                                (bus.mem_reg_write & (bus.id_rt_addr == bus.mem_dst_addr))));

  assign rs_fwd = id_ex_q.rs_data;
  assign rt_fwd = id_ex_q.rt_data;
`endif

  // Next ID/EX contents: a bubble on flush or stall, otherwise the ID fields
  // with control qualified by id_valid.
  always_comb begin
    // NOTE: assigning the whole struct first gives every bit a value on every
    // path, so no latch can be inferred and the bubble is the default.
    id_ex_d = '0;
    if (!bus.flush && !stall) begin
      id_ex_d.valid     = bus.id_valid;
      id_ex_d.rs_addr   = bus.id_rs_addr;
      id_ex_d.rt_addr   = bus.id_rt_addr;
      id_ex_d.dst_addr  = bus.id_dst_addr;
      id_ex_d.uses_rs   = bus.id_uses_rs;
      id_ex_d.uses_rt   = bus.id_uses_rt;
      id_ex_d.rs_data   = bus.id_rs_data;
      id_ex_d.rt_data   = bus.id_rt_data;
      id_ex_d.imm       = bus.id_imm;
      id_ex_d.alu_src   = bus.id_alu_src;
      id_ex_d.alu_op    = bus.id_alu_op;
      id_ex_d.reg_write = bus.id_reg_write & bus.id_valid;
      id_ex_d.mem_read  = bus.id_mem_read & bus.id_valid;
      id_ex_d.mem_write = bus.id_mem_write & bus.id_valid;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every register sampling pre-edge
    // values, independent of process ordering.
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign bus.stall         = stall;
  assign bus.alu_a         = rs_fwd;
  assign bus.alu_b         = id_ex_q.alu_src ? id_ex_q.imm : rt_fwd;
  assign bus.alu_op        = id_ex_q.alu_op;
  assign bus.ex_store_data = rt_fwd;
  assign bus.ex_valid      = id_ex_q.valid;
  assign bus.ex_reg_write  = id_ex_q.reg_write;
  assign bus.ex_mem_read   = id_ex_q.mem_read;
  assign bus.ex_mem_write  = id_ex_q.mem_write;
  assign bus.ex_dst_addr   = id_ex_q.dst_addr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_operand_stage
//   Self-checking bench for ex_operand_stage: a table of single-instruction
//   operand-selection vectors, hand-written multi-cycle hazard sequences, and
//   a randomized run checked against an instruction-level reference model.
//   Works for both FORWARD_EN builds.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex_operand_stage;
  localparam int DW = 32;
  localparam int RW = 5;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.DW(DW), .RW(RW)) bus ();
  ex_operand_stage #(.DW(DW), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs, rt, dst;
    logic          urs, urt;
    logic [DW-1:0] rsd, rtd, imm;
    logic          src;
    logic [2:0]    op;
    logic          rw, mr, mw;
  } ins_t;

  typedef struct {
    logic [RW-1:0] rs, rt;
    logic          urs, urt;
    logic [DW-1:0] rsd, rtd, imm;
    logic          src;
    logic [2:0]    op;
    logic          mrw;
    logic [RW-1:0] md;
    logic [DW-1:0] mres;
    logic          wrw;
    logic [RW-1:0] wd;
    logic [DW-1:0] wres;
    logic [DW-1:0] ea, eb, es;  // expected with forwarding
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Producer state as currently driven (youngest first: EX/MEM, MEM/WB).
  logic          p_we  [2];
  logic [RW-1:0] p_dst [2];
  logic [DW-1:0] p_res [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input ins_t i);
    bus.id_valid     = i.valid;
    bus.id_rs_addr   = i.rs;
    bus.id_rt_addr   = i.rt;
    bus.id_dst_addr  = i.dst;
    bus.id_uses_rs   = i.urs;
    bus.id_uses_rt   = i.urt;
    bus.id_rs_data   = i.rsd;
    bus.id_rt_data   = i.rtd;
    bus.id_imm       = i.imm;
    bus.id_alu_src   = i.src;
    bus.id_alu_op    = i.op;
    bus.id_reg_write = i.rw;
    bus.id_mem_read  = i.mr;
    bus.id_mem_write = i.mw;
  endtask

  task automatic set_prod(input logic mwe, input logic [RW-1:0] md, input logic [DW-1:0] mr,
                          input logic wwe, input logic [RW-1:0] wd, input logic [DW-1:0] wr);
    p_we[0] = mwe; p_dst[0] = md; p_res[0] = mr;
    p_we[1] = wwe; p_dst[1] = wd; p_res[1] = wr;
    bus.mem_reg_write = mwe; bus.mem_dst_addr = md; bus.mem_result = mr;
    bus.wb_reg_write  = wwe; bus.wb_dst_addr  = wd; bus.wb_result  = wr;
  endtask

  // Operand value an instruction in EX should see: the youngest in-flight
  // producer of that register if forwarding exists, else what it read in ID.
  function automatic logic [DW-1:0] operand(input logic used, input logic [RW-1:0] a,
                                            input logic [DW-1:0] d);
    if (!FWD || !used || a == 0) return d;
    for (int k = 0; k < 2; k++)
      if (p_we[k] && p_dst[k] == a) return p_res[k];
    return d;
  endfunction

  // Does the ID instruction have to wait, given what is in EX and MEM?
  function automatic logic model_stall(input ins_t id, input ins_t ex);
    logic [RW-1:0] srcs [2];
    logic          used [2];
    srcs[0] = id.rs; used[0] = id.urs;
    srcs[1] = id.rt; used[1] = id.urt;
    for (int k = 0; k < 2; k++) begin
      if (id.valid && used[k] && srcs[k] != 0) begin
        if (FWD) begin
          if (ex.valid && ex.mr && ex.dst == srcs[k]) return 1'b1;
        end else begin
          if (ex.valid && ex.rw && ex.dst == srcs[k]) return 1'b1;
          if (p_we[0] && p_dst[0] == srcs[k]) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic ins_t enter_ex(input ins_t id);
    ins_t r = id;
    r.rw = id.rw & id.valid;
    r.mr = id.mr & id.valid;
    r.mw = id.mw & id.valid;
    return r;
  endfunction

  task automatic check_all(input string tag, input ins_t ex, input logic exp_stall);
    logic [DW-1:0] a, rt;
    a  = operand(ex.urs, ex.rs, ex.rsd);
    rt = operand(ex.urt, ex.rt, ex.rtd);
    check({tag, " stall"}, bus.stall, exp_stall);
    check({tag, " alu_a"}, bus.alu_a, a);
    check({tag, " alu_b"}, bus.alu_b, ex.src ? ex.imm : rt);
    check({tag, " alu_op"}, bus.alu_op, ex.op);
    check({tag, " store"}, bus.ex_store_data, rt);
    check({tag, " ctrl"}, {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read,
                           bus.ex_mem_write, bus.ex_dst_addr},
          {ex.valid, ex.rw, ex.mr, ex.mw, ex.dst});
  endtask

  function automatic vec_t mk(
    input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic urs, input logic urt,
    input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
    input logic src, input logic [2:0] op,
    input logic mrw, input logic [RW-1:0] md, input logic [DW-1:0] mres,
    input logic wrw, input logic [RW-1:0] wd, input logic [DW-1:0] wres,
    input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic [DW-1:0] es);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rsd = rsd; v.rtd = rtd;
    v.imm = imm; v.src = src; v.op = op; v.mrw = mrw; v.md = md; v.mres = mres;
    v.wrw = wrw; v.wd = wd; v.wres = wres; v.ea = ea; v.eb = eb; v.es = es;
    return v;
  endfunction

  // Producer (register 5) enters EX, dependent consumer (rt=5) waits in ID.
  // pos tracks where the producer is: 1=EX, 2=MEM, 3=WB, 4=retired.
  task automatic drive_pipe(input int pos);
    case (pos)
      2:       set_prod(1'b1, 5'd5, 32'h0000_AAAA, 1'b0, 5'd0, 32'h0);
      3:       set_prod(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_BEEF);
      default: set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endcase
  endtask

  task automatic dep_seq(input string tag, input logic is_load, input int exp_stalls,
                         input logic [DW-1:0] exp_b);
    ins_t p, c;
    int   pos, n;
    logic done;
    p = '0; c = '0;
    p.valid = 1'b1; p.dst = 5'd5; p.rw = 1'b1; p.mr = is_load; p.op = 3'b010;
    drive_id(p);
    drive_pipe(0);
    @(posedge clk); #1;
    c.valid = 1'b1; c.urs = 1'b1; c.rs = 5'd1; c.rsd = 32'h11;
    c.urt = 1'b1; c.rt = 5'd5; c.rtd = 32'h1234; c.op = 3'b100; c.dst = 5'd6; c.rw = 1'b1;
    drive_id(c);
    pos = 1; n = 0; done = 1'b0;
    for (int cyc = 0; cyc < 6 && !done; cyc++) begin
      drive_pipe(pos);
      #1;
      if (bus.stall) n++;
      else           done = 1'b1;
      @(posedge clk); #1;
      pos++;
      if (!done) check({tag, " bubble"}, bus.ex_valid, 1'b0);
    end
    check({tag, " captured"}, done, 1'b1);
    drive_id('0);
    drive_pipe(pos);
    #1;
    check({tag, " stalls"}, n, exp_stalls);
    check({tag, " ex_valid"}, bus.ex_valid, 1'b1);
    check({tag, " alu_a"}, bus.alu_a, 32'h11);
    check({tag, " alu_b"}, bus.alu_b, exp_b);
    check({tag, " alu_op"}, bus.alu_op, 3'b100);
  endtask

  initial begin
    vec_t vt[7];
    ins_t i, ex_m;
    logic st, rr, ff;

    vt[0] = mk(3, 4, 1, 1, 32'h1111, 32'h2222, 0, 0, 3'b010, 1, 3, 32'h10, 0, 0, 0,
               32'h10, 32'h2222, 32'h2222);
    vt[1] = mk(3, 4, 1, 1, 32'h1111, 32'h2222, 0, 0, 3'b010, 1, 3, 32'h10, 1, 3, 32'h99,
               32'h10, 32'h2222, 32'h2222);
    vt[2] = mk(3, 4, 1, 1, 32'h1111, 32'h2222, 0, 0, 3'b001, 1, 7, 32'h70, 1, 3, 32'h99,
               32'h99, 32'h2222, 32'h2222);
    vt[3] = mk(0, 4, 1, 1, 32'h0, 32'h2222, 0, 0, 3'b000, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF,
               32'h0, 32'h2222, 32'h2222);
    vt[4] = mk(1, 6, 1, 1, 32'h1, 32'h66, 32'hFFFF_FFFC, 1, 3'b010, 1, 6, 32'h77, 0, 0, 0,
               32'h1, 32'hFFFF_FFFC, 32'h77);
    vt[5] = mk(3, 4, 0, 1, 32'h3333, 32'h44, 0, 0, 3'b101, 1, 3, 32'h10, 1, 4, 32'h45,
               32'h3333, 32'h45, 32'h45);
    vt[6] = mk(2, 5, 1, 1, 32'h20, 32'h50, 0, 0, 3'b110, 0, 5, 32'hAA, 1, 5, 32'h55,
               32'h20, 32'h55, 32'h55);

    // Reset held two cycles with a valid instruction presented.
    rst = 1'b1; bus.flush = 1'b0;
    i = '0; i.valid = 1'b1; i.rw = 1'b1; i.mr = 1'b1; i.mw = 1'b1; i.dst = 5'd7;
    i.op = 3'b110; i.rsd = 32'h5; i.urs = 1'b1; i.rs = 5'd2;
    drive_id(i);
    set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", '0, 1'b0);
    rst = 1'b0;

    // Table: one instruction per entry, producers set in its EX cycle.
    for (int k = 0; k < 7; k++) begin
      i = '0; i.valid = 1'b1; i.rs = vt[k].rs; i.rt = vt[k].rt; i.urs = vt[k].urs;
      i.urt = vt[k].urt; i.rsd = vt[k].rsd; i.rtd = vt[k].rtd; i.imm = vt[k].imm;
      i.src = vt[k].src; i.op = vt[k].op; i.rw = 1'b1; i.dst = 5'd9;
      drive_id(i);
      set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(posedge clk); #1;
      drive_id('0);
      set_prod(vt[k].mrw, vt[k].md, vt[k].mres, vt[k].wrw, vt[k].wd, vt[k].wres);
      #1;
      check($sformatf("vec%0d alu_a", k), bus.alu_a, FWD ? vt[k].ea : vt[k].rsd);
      check($sformatf("vec%0d alu_b", k), bus.alu_b,
            FWD ? vt[k].eb : (vt[k].src ? vt[k].imm : vt[k].rtd));
      check($sformatf("vec%0d store", k), bus.ex_store_data, FWD ? vt[k].es : vt[k].rtd);
      check($sformatf("vec%0d alu_op", k), bus.alu_op, vt[k].op);
      check($sformatf("vec%0d ctrl", k), {bus.ex_valid, bus.ex_reg_write, bus.ex_dst_addr},
            {1'b1, 1'b1, 5'd9});
      @(posedge clk); #1;
    end

    // Dependent pairs: load costs 1 bubble with forwarding, any producer 2 without.
    dep_seq("load-use", 1'b1, FWD ? 1 : 2, FWD ? 32'h0000_BEEF : 32'h1234);
    dep_seq("alu-dep", 1'b0, FWD ? 0 : 2, FWD ? 32'h0000_AAAA : 32'h1234);

    // Flush while a load-use stall is active: bubble goes in, stall still shown.
    set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    i = '0; i.valid = 1'b1; i.dst = 5'd5; i.rw = 1'b1; i.mr = 1'b1;
    drive_id(i);
    @(posedge clk); #1;
    i = '0; i.valid = 1'b1; i.urt = 1'b1; i.rt = 5'd5; i.rw = 1'b1; i.dst = 5'd8;
    drive_id(i);
    bus.flush = 1'b1;
    #1;
    check("flush+stall stall", bus.stall, 1'b1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    drive_id('0);
    #1;
    check("flush+stall ex_valid", bus.ex_valid, 1'b0);
    check("flush+stall ex_reg_write", bus.ex_reg_write, 1'b0);

    // Reset during a stall: register clears, stall drops next cycle.
    i = '0; i.valid = 1'b1; i.dst = 5'd5; i.rw = 1'b1; i.mr = 1'b1;
    drive_id(i);
    @(posedge clk); #1;
    i = '0; i.valid = 1'b1; i.urs = 1'b1; i.rs = 5'd5; i.rw = 1'b1; i.dst = 5'd8;
    drive_id(i);
    rst = 1'b1;
    #1;
    check("rst-in-stall stall before", bus.stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst-in-stall stall after", bus.stall, 1'b0);
    check("rst-in-stall ex_valid", bus.ex_valid, 1'b0);

    // Randomized run against the instruction-level model.
    rst = 1'b1; drive_id('0);
    @(posedge clk); #1;
    rst = 1'b0;
    ex_m = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      i = '0;
      i.valid = ($urandom_range(0, 3) != 0);
      i.rs = RW'($urandom_range(0, 3));
      i.rt = RW'($urandom_range(0, 3));
      i.dst = RW'($urandom_range(0, 3));
      i.urs = i.valid & ($urandom_range(0, 1) == 1);
      i.urt = i.valid & ($urandom_range(0, 1) == 1);
      i.rsd = $urandom; i.rtd = $urandom; i.imm = $urandom;
      i.src = ($urandom_range(0, 1) == 1);
      i.op = 3'($urandom_range(0, 7));
      i.rw = ($urandom_range(0, 1) == 1);
      i.mr = ($urandom_range(0, 1) == 1);
      i.mw = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 31) == 0);
      ff = ($urandom_range(0, 7) == 0);
      drive_id(i);
      rst = rr; bus.flush = ff;
      set_prod($urandom_range(0, 1) == 1, RW'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 1) == 1, RW'($urandom_range(0, 3)), $urandom);
      #1;
      st = model_stall(i, ex_m);
      check($sformatf("rand%0d", cyc), {63'b0, 1'b0}, {63'b0, 1'b0} ^ 64'(bus.stall ^ st));
      check_all($sformatf("rand%0d", cyc), ex_m, st);
      @(posedge clk);
      if (rr)            ex_m = '0;
      else if (ff || st) ex_m = '0;
      else               ex_m = enter_ex(i);
      #1;
    end
    rst = 1'b0; bus.flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register plus EX-stage operand selection for the 5-stage MIPS pipeline, sitting directly upstream of the ALU. It captures decoded instructions from ID and resolves RAW hazards, either by forwarding from EX/MEM and MEM/WB or by stalling. It drives the ALU's `A`, `B` and 3-bit `Op` inputs, and forwards control and destination information to EX/MEM.

## Interface
- `DW`, 32, datapath width (ALU operand width)
- `RW`, 5, register address width
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `id_valid` in 1: ID holds a real instruction
- `id_rs_addr`, `id_rt_addr`, `id_dst_addr` in RW: source and destination register numbers
- `id_uses_rs`, `id_uses_rt` in 1: the instruction reads rs / rt
- `id_rs_data`, `id_rt_data` in DW: register file read data (the register file is write-through, so WB-stage writes are already visible)
- `id_imm` in DW: sign/zero-extended immediate
- `id_alu_src` in 1: 1 selects `id_imm` as B, 0 selects rt
- `id_alu_op` in 3: ALU op code (000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT)
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control bits
- `flush` in 1: branch/jump redirect; kills the instruction entering EX
- `mem_reg_write` in 1, `mem_dst_addr` in RW, `mem_result` in DW: EX/MEM producer
- `wb_reg_write` in 1, `wb_dst_addr` in RW, `wb_result` in DW: MEM/WB producer
- `stall` out 1: holds PC and IF/ID this cycle (combinational)
- `alu_a`, `alu_b` out DW: ALU operands
- `alu_op` out 3: ALU op code
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered control
- `ex_dst_addr` out RW: registered destination
- `ex_store_data` out DW: forwarded rt value for stores

## Operation
- ID/EX register fields: valid, rs/rt addresses, uses_rs/uses_rt, rs/rt data, imm, alu_src, alu_op, reg_write, mem_read, mem_write, dst_addr.
- Load-use hazard:
  - Condition: `id_valid & ex_valid & ex_mem_read & ex_dst_addr!=0` and (`id_uses_rs & id_rs_addr==ex_dst_addr`, or `id_uses_rt & id_rt_addr==ex_dst_addr`).
  - Response: `stall=1`.
- On each edge, evaluated in priority order:
  1. `rst`: zero all fields.
  2. `flush`: load a bubble (valid and all control bits 0; data don't-care, driven 0). Flush beats stall.
  3. `stall`: load a bubble. ID holds the instruction, so it re-presents next cycle.
  4. Otherwise: capture all ID fields. `valid=id_valid`; control bits are ANDed with `id_valid`.
- Forwarding, per source operand X in {rs, rt} (combinational from registered fields):
  - When the operand is used and `X_addr!=0`:
    - if `mem_reg_write & mem_dst_addr==X_addr`, select `mem_result`;
    - else if `wb_reg_write & wb_dst_addr==X_addr`, select `wb_result`;
    - else select the registered data.
  - MEM has priority over WB. Register 0 is never forwarded and always reads the registered value, which is 0.
- Outputs:
  - `alu_a` = forwarded rs.
  - `alu_b` = `alu_src ? imm : forwarded rt`.
  - `ex_store_data` = forwarded rt, independent of `alu_src`.
  - `alu_op` = registered op; it is 000 for a bubble, so AND of zeros gives 0.
- Arithmetic: no width change. All buses are DW bits; no sign or overflow handling here.

## Timing
- 1-cycle latency from ID fields to ALU inputs. Forwarding muxes are combinational in the EX cycle.
- Reset values: every output is 0, and `stall=0`.
- A load followed immediately by a dependent instruction costs exactly 1 bubble. In the next cycle the load is in MEM, but MEM-stage load data is not forwarded; the WB-stage value is forwarded one cycle later. Therefore the stall persists while the load sits in EX only; after the bubble, the load is in MEM/WB and the consumer reads `wb_result` in its EX cycle.
- Stall and flush in the same cycle: a bubble is inserted and `stall` stays asserted. The upstream flush overrides it.
- Reset asserted mid-stall: the register clears and `stall` drops in the following cycle.

## Configuration
- `FORWARD_EN` defined: forwarding as described; the only stall source is load-use.
- `FORWARD_EN` undefined:
  - Forwarding muxes are removed and operands come straight from the registered data.
  - `stall` asserts whenever a used, nonzero ID source matches either:
    - (`ex_valid & ex_reg_write & ex_dst_addr`), or
    - (`mem_reg_write & mem_dst_addr`).
  - WB matches never stall because the register file is write-through.
  - A back-to-back dependent ALU pair costs 2 bubbles.

## Test plan
- Reset: hold `rst` 2 cycles with `id_valid=1` -> all outputs 0, `stall=0`, `alu_op=000`.
- Forward from MEM: `add $3` result `mem_result=0x0000_0010`, `mem_dst_addr=3`; consumer rs=3 -> `alu_a=0x10`. With WB also targeting $3 (`wb_result=0x99`), MEM still wins.
- Load-use: `lw $5` in EX, ID `sub` with rt=5 -> `stall=1` for 1 cycle, then a bubble in EX (`ex_valid=0`), then `alu_b=wb_result`.
- Register 0: `mem_dst_addr=0`, `mem_reg_write=1`, consumer rs=0 -> `alu_a=0`. Immediate path: `alu_src=1`, `imm=0xFFFF_FFFC` -> `alu_b=0xFFFF_FFFC`, `ex_store_data` = forwarded rt.
- Flush during stall: load-use and `flush=1` together -> next cycle `ex_valid=0`, `ex_reg_write=0`.
- Without `FORWARD_EN`: `add $2` then `or` reading $2 -> `stall=1` for exactly 2 cycles, then the `or` sees the register-file value.
